norgate_resp_checker: RTL and testbench
=======================================

// Module: norgate_resp_checker
// PURPOSE
//  Response-side counterpart to the norgate stimulus driver.
//  Consumes vector triples (a, b, c): a/b are the operands applied to a norgate instance, c is its observed output.
//  Checks c against ~(a|b), counts and logs failures, and compacts every c into a MISR signature.
//  Sits beside the gate IP in the Teacher-Core self-test harness; a test session is armed by start and ends with done.
// PARAMETERS
//  WIDTH      32            data width of a, b, c (matches norgate #(WIDTH))
//  CNT_W      16            width of vector, error and index counters
//  MISR_POLY  32'h04C11DB7  MISR feedback polynomial, low WIDTH bits used
//  MISR_SEED  {WIDTH{1'b1}} MISR value loaded at session start
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      synchronous active-low reset
//  start          in   1      pulse: begin session (honoured in IDLE/DONE only)
//  num_vec        in   CNT_W  vectors in session; sampled on accepted start
//  in_valid       in   1      a/b/c triple valid
//  in_ready       out  1      checker can accept a triple
//  a, b           in   WIDTH  operands applied to the gate
//  c              in   WIDTH  observed gate output
//  busy           out  1      session in progress (RUN)
//  done           out  1      session complete; level, held until next start
//  pass           out  1      valid while done: 1 iff err_cnt==0
//  vec_cnt        out  CNT_W  triples accepted this session
//  err_cnt        out  CNT_W  mismatching triples, saturates at all-ones
//  first_err_idx  out  CNT_W  vec_cnt index (0-based) of first mismatch
//  first_err_c    out  WIDTH  observed c of first mismatch
//  signature      out  WIDTH  current MISR value
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE; all outputs 0 except signature=MISR_SEED; applies mid-session with no residue.
//  States: IDLE -> RUN -> DONE -> (start) RUN.
//  IDLE/DONE + start:
//   - clear vec_cnt, err_cnt, first_err_*; signature<=MISR_SEED; latch num_vec; done<=0.
//   - num_vec==0: go directly to DONE (done=1, pass=1 the next cycle).
//   - otherwise go to RUN.
//  RUN: in_ready=1, busy=1; start ignored.
//  Accept = in_valid & in_ready. Per accept, all updates registered (1-cycle latency):
//   - exp = ~(a|b) over WIDTH bits; mis = (c != exp).
//   - vec_cnt += 1.
//   - if mis: err_cnt += 1 unless all-ones.
//   - if mis and err_cnt==0: first_err_idx <= vec_cnt (pre-increment); first_err_c <= c.
//   - signature <= {sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? MISR_POLY : 0) ^ c.
//  Completion: accept with vec_cnt==num_lat-1 -> DONE next cycle; in_ready drops that same next cycle, so no extra accept.
//  DONE: in_ready=0, busy=0, done=1, pass=(err_cnt==0); counters and signature frozen.
//  in_valid while not RUN is ignored (no count, no MISR update).
//  a/b/c are sampled only on accept; X on inputs outside accept has no effect.
// STRUCTURE
//  Package norgate_chk_pkg: state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2), default MISR_POLY and MISR_SEED.
//  Sub-module misr_reg #(WIDTH, POLY, SEED):
//   - inputs: clk, rst_n, load_seed, en, din; output: sig.
//   - instantiated once.
//  FSM, counters and compare stay in this module.
// TESTING
//  1 Reset mid-RUN after 3 accepts -> next cycle vec_cnt=0, busy=0, in_ready=0, signature=MISR_SEED.
//  2 num_vec=4; triples (0,0,FFFFFFFF), (FFFFFFFF,0,0), (0,FFFFFFFF,0), (FFFFFFFF,FFFFFFFF,0):
//    -> done=1, pass=1, err_cnt=0, vec_cnt=4.
//  3 num_vec=3; second triple a=0, b=007FA509, c=FF805AF7 (one bit flipped from FF805AF6):
//    -> err_cnt=1, first_err_idx=1, first_err_c=FF805AF7, pass=0.
//  4 num_vec=0 with start -> done=1, pass=1 next cycle, in_ready never high.
//  5 num_vec=2, in_valid held high: exactly 2 accepts, then in_ready=0.
//    start pulses during RUN have no effect.
//    A later start from DONE restarts with cleared counters.
//  6 Random 1000 vectors with injected faults:
//    -> err_cnt, first_err_* and signature equal a bench reference model bit-for-bit.

Source files
------------

// File: rtl/norgate_chk_pkg.sv
// Shared types and defaults for the norgate response checker.
package norgate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [31:0] DEF_MISR_POLY = 32'h04C11DB7;
    localparam logic [31:0] DEF_MISR_SEED = 32'hFFFFFFFF;

endpackage

// File: rtl/norgate_resp_checker_misr.sv
// Multiple-input signature register: shift left, fold MSB through POLY, xor in din.
module misr_reg
    import norgate_chk_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = DEF_MISR_POLY[WIDTH-1:0],
    parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_seed,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load_seed) begin
            sig_d = SEED;
        end else if (en) begin
            sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/norgate_resp_checker.sv
// Checks observed NOR outputs against ~(a|b), tracks errors and compacts c into a MISR.
module norgate_resp_checker
    import norgate_chk_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               CNT_W     = 16,
    parameter logic [31:0]      MISR_POLY = DEF_MISR_POLY,
    parameter logic [WIDTH-1:0] MISR_SEED = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_c,
    output logic [WIDTH-1:0] signature
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] fidx_q, fidx_d;
    logic [WIDTH-1:0] fc_q, fc_d;

    logic             accept;
    logic             start_ok;
    logic             mis;

    assign accept   = in_valid && (state_q == RUN);
    assign start_ok = start && (state_q != RUN);
    assign mis      = (c != ~(a | b));

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        vec_cnt_d = vec_cnt_q;
        err_cnt_d = err_cnt_q;
        fidx_d    = fidx_q;
        fc_d      = fc_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    num_d     = num_vec;
                    vec_cnt_d = '0;
                    err_cnt_d = '0;
                    fidx_d    = '0;
                    fc_d      = '0;
                    state_d   = (num_vec == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    vec_cnt_d = vec_cnt_q + CNT_W'(1);
                    if (mis) begin
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
                        if (err_cnt_q == '0) begin
                            fidx_d = vec_cnt_q;
                            fc_d   = c;
                        end
                    end
                    // Last vector: leaving RUN drops in_ready before another accept can happen.
                    if (vec_cnt_q == num_q - CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            num_q     <= '0;
            vec_cnt_q <= '0;
            err_cnt_q <= '0;
            fidx_q    <= '0;
            fc_q      <= '0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            vec_cnt_q <= vec_cnt_d;
            err_cnt_q <= err_cnt_d;
            fidx_q    <= fidx_d;
            fc_q      <= fc_d;
        end
    end

    misr_reg #(
        .WIDTH (WIDTH),
        .POLY  (MISR_POLY[WIDTH-1:0]),
        .SEED  (MISR_SEED)
    ) u_misr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_seed (start_ok),
        .en        (accept),
        .din       (c),
        .sig       (signature)
    );

    assign in_ready      = (state_q == RUN);
    assign busy          = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign pass          = (state_q == DONE) && (err_cnt_q == '0);
    assign vec_cnt       = vec_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = fidx_q;
    assign first_err_c   = fc_q;

endmodule

// File: tb/tb_norgate_resp_checker.sv
// Scoreboard bench: session results are queued at issue and checked when done rises.
module tb_norgate_resp_checker;

    localparam int          WIDTH = 32;
    localparam int          CNT_W = 16;
    localparam logic [31:0] POLY  = 32'h04C11DB7;
    localparam logic [31:0] SEED  = 32'hFFFFFFFF;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] num_vec;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b, c;
    logic             busy, done, pass;
    logic [CNT_W-1:0] vec_cnt, err_cnt, first_err_idx;
    logic [WIDTH-1:0] first_err_c, signature;

    norgate_resp_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .c(c),
        .busy(busy), .done(done), .pass(pass), .vec_cnt(vec_cnt),
        .err_cnt(err_cnt), .first_err_idx(first_err_idx),
        .first_err_c(first_err_c), .signature(signature)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CNT_W-1:0] vec;
        logic [CNT_W-1:0] err;
        logic [CNT_W-1:0] idx;
        logic [WIDTH-1:0] fc;
        logic [WIDTH-1:0] sig;
        logic             pass;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic [WIDTH-1:0] va [0:1023];
    logic [WIDTH-1:0] vb [0:1023];
    logic [WIDTH-1:0] vc [0:1023];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] fb;
        fb = s[WIDTH-1] ? POLY : 32'h0;
        return {s[WIDTH-2:0], 1'b0} ^ fb ^ d;
    endfunction

    // Reference model over va/vb/vc[0:n-1]; result goes into the scoreboard.
    task automatic model_session(input int n);
        exp_t e;
        e.vec = '0; e.err = '0; e.idx = '0; e.fc = '0; e.sig = SEED;
        for (int i = 0; i < n; i++) begin
            if (vc[i] != ~(va[i] | vb[i])) begin
                if (e.err == 0) begin
                    e.idx = CNT_W'(i);
                    e.fc  = vc[i];
                end
                if (e.err != 16'hFFFF) e.err = e.err + 1;
            end
            e.sig = misr_step(e.sig, vc[i]);
            e.vec = e.vec + 1;
        end
        e.pass = (e.err == 0);
        sb.push_back(e);
    endtask

    task automatic do_start(input int n);
        @(negedge clk);
        start   = 1'b1;
        num_vec = CNT_W'(n);
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic send_one(input int i);
        logic r;
        int   tries;
        tries = 0;
        in_valid = 1'b1;
        a = va[i]; b = vb[i]; c = vc[i];
        do begin
            r = in_ready;
            @(negedge clk);
            tries++;
        end while (!r && tries < 20);
        if (!r) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; c = $urandom;
    endtask

    task automatic send_all(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            send_one(i);
            if (gaps && ($urandom_range(0, 3) == 0)) @(negedge clk);
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    // Monitor: pops an expectation on every rising edge of done.
    initial begin
        logic dp;
        exp_t e;
        dp = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !dp) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_vec_cnt",   vec_cnt,       e.vec);
                    chk("sb_err_cnt",   err_cnt,       e.err);
                    chk("sb_first_idx", first_err_idx, e.idx);
                    chk("sb_first_c",   first_err_c,   e.fc);
                    chk("sb_signature", signature,     e.sig);
                    chk("sb_pass",      pass,          e.pass);
                end
            end
            dp = done;
        end
    end

    initial begin
        int   acc;
        logic ir_seen;
        rst_n = 1'b0; start = 1'b0; num_vec = '0; in_valid = 1'b0;
        a = '0; b = '0; c = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vec_cnt",  vec_cnt,   0);
        chk("rst_busy",     busy,      0);
        chk("rst_done",     done,      0);
        chk("rst_pass",     pass,      0);
        chk("rst_err_cnt",  err_cnt,   0);
        chk("rst_sig",      signature, SEED);
        rst_n = 1'b1;

        // 1: reset mid-RUN after three accepts
        for (int i = 0; i < 3; i++) begin
            va[i] = 32'h1234_0000 + i; vb[i] = 32'h0; vc[i] = ~va[i];
        end
        do_start(10);
        send_all(3, 0);
        chk("mid_vec_cnt3", vec_cnt, 3);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_vec_cnt",  vec_cnt,   0);
        chk("mrst_busy",     busy,      0);
        chk("mrst_in_ready", in_ready,  0);
        chk("mrst_sig",      signature, SEED);
        chk("mrst_done",     done,      0);
        rst_n = 1'b1;

        // 4: empty session
        model_session(0);
        do_start(0);
        chk("nv0_done", done, 1);
        chk("nv0_pass", pass, 1);
        ir_seen = in_ready;
        repeat (4) begin
            @(negedge clk);
            ir_seen = ir_seen | in_ready;
        end
        chk("nv0_in_ready_never", ir_seen, 0);

        // 2: four correct triples
        va[0] = 32'h0;        vb[0] = 32'h0;        vc[0] = 32'hFFFFFFFF;
        va[1] = 32'hFFFFFFFF; vb[1] = 32'h0;        vc[1] = 32'h0;
        va[2] = 32'h0;        vb[2] = 32'hFFFFFFFF; vc[2] = 32'h0;
        va[3] = 32'hFFFFFFFF; vb[3] = 32'hFFFFFFFF; vc[3] = 32'h0;
        model_session(4);
        do_start(4);
        chk("t2_busy", busy, 1);
        send_all(4, 0);
        wait_done();
        chk("t2_done", done, 1);
        chk("t2_pass", pass, 1);
        chk("t2_vec",  vec_cnt, 4);

        // 3: one flipped bit in the second triple
        va[0] = 32'h0;        vb[0] = 32'h0;        vc[0] = 32'hFFFFFFFF;
        va[1] = 32'h0;        vb[1] = 32'h007FA509; vc[1] = 32'hFF805AF7;
        va[2] = 32'hFFFFFFFF; vb[2] = 32'h0;        vc[2] = 32'h0;
        model_session(3);
        do_start(3);
        send_all(3, 1);
        wait_done();
        chk("t3_err_cnt", err_cnt,       1);
        chk("t3_idx",     first_err_idx, 1);
        chk("t3_fc",      first_err_c,   32'hFF805AF7);
        chk("t3_pass",    pass,          0);

        // 5: in_valid held high with start pulses during RUN
        va[0] = 32'h1; vb[0] = 32'h2; vc[0] = 32'hFFFFFFFC;
        va[1] = 32'h1; vb[1] = 32'h2; vc[1] = 32'hFFFFFFFC;
        model_session(2);
        do_start(2);
        in_valid = 1'b1; a = 32'h1; b = 32'h2; c = 32'hFFFFFFFC;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            if (in_valid && in_ready) acc++;
            start   = (k == 1);
            num_vec = 16'd5;
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0;
        chk("t5_accepts",  acc,      2);
        chk("t5_in_ready", in_ready, 0);
        chk("t5_vec",      vec_cnt,  2);
        va[0] = 32'h0; vb[0] = 32'h0; vc[0] = 32'h0;
        model_session(1);
        do_start(1);
        chk("t5r_vec_clr", vec_cnt, 0);
        chk("t5r_err_clr", err_cnt, 0);
        chk("t5r_busy",    busy,    1);
        chk("t5r_sig",     signature, SEED);
        send_all(1, 0);
        wait_done();
        chk("t5r_err", err_cnt,       1);
        chk("t5r_idx", first_err_idx, 0);
        chk("t5r_fc",  first_err_c,   0);

        // 6: 1000 random vectors with injected faults
        for (int i = 0; i < 1000; i++) begin
            va[i] = $urandom; vb[i] = $urandom & $urandom;
            vc[i] = ~(va[i] | vb[i]);
            if ($urandom_range(0, 7) == 0) vc[i] = vc[i] ^ (32'h1 << $urandom_range(0, 31));
        end
        model_session(1000);
        do_start(1000);
        send_all(1000, 1);
        wait_done();
        chk("t6_vec", vec_cnt, 1000);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
